uart_tx_port: RTL and testbench

Memory-mapped UART transmitter on the single-cycle MIPS processor's data bus, in parallel with the data memory. Stores to the TX data address push bytes into a small FIFO. A baud-rate FSM serializes them as 8N1 frames on `tx`. Loads from the status address return FIFO and transmitter state.

---
 rtl/uart_tx_port.sv | 116 +++++++++++
 tb/tb_uart_tx_port.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped UART transmitter with TX FIFO; define UART_TX_PARITY_EN for an even parity bit
module uart_tx_port #(
  parameter int BAUD_DIV = 434,
  parameter int FIFO_DEPTH = 4,
  parameter logic [31:0] DATA_ADDR = 32'h1001FFF0,
  parameter logic [31:0] STATUS_ADDR = 32'h1001FFF4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);
  localparam logic [PW:0] DEPTH = (PW + 1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} stateT;
  stateT state, stateNext;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [PW:0] count;
  logic [15:0] cnt;
  logic [2:0] bitIdx;
  logic [7:0] shift;
  logic overflow, full, empty, dataWr, push, pop, statusRd, wrap;
  logic unusedBits;
`ifdef UART_TX_PARITY_EN
  logic parBit;
`endif
  assign full = count == DEPTH;
  assign empty = count == '0;
  assign dataWr = MemWrite && Address == DATA_ADDR;
  assign push = dataWr && !full;
  assign statusRd = MemRead && Address == STATUS_ADDR;
  assign wrap = cnt == LAST;
  assign busy = state != IDLE;
  assign ReadData = (Address == STATUS_ADDR) ? {28'b0, overflow, busy, empty, full} : 32'b0;
  assign unusedBits = ^WriteData[31:8];
  // FIFO storage; contents are discarded on reset by clearing the pointers only
  always_ff @(posedge clk)
    if (push) mem[wrPtr] <= WriteData[7:0];
  // FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop) rdPtr <= rdPtr + PW'(1);
      count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
      overflow <= (dataWr && full) ? 1'b1 : statusRd ? 1'b0 : overflow;
    end
  // FSM state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= stateNext;
  // Baud counter, bit index and shift register
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      bitIdx <= '0;
      shift <= '0;
`ifdef UART_TX_PARITY_EN
      parBit <= 1'b0;
`endif
    end else begin
      cnt <= (state == IDLE || wrap) ? '0 : cnt + 16'd1;
      if (state == DATA && wrap) bitIdx <= bitIdx + 3'd1;
      if (pop) shift <= mem[rdPtr];
      else if (state == DATA && wrap) shift <= shift >> 1;
`ifdef UART_TX_PARITY_EN
      if (pop) parBit <= ^mem[rdPtr];
`endif
    end
  // Next state, FIFO pop and line level; the stop bit chains straight into the next start bit
  always_comb begin
    stateNext = state;
    pop = 1'b0;
    tx = 1'b1;
    case (state)
      IDLE: begin
        pop = !empty;
        stateNext = empty ? IDLE : START;
      end
      START: begin
        tx = 1'b0;
        stateNext = wrap ? DATA : START;
      end
      DATA: begin
        tx = shift[0];
`ifdef UART_TX_PARITY_EN
        stateNext = (wrap && bitIdx == 3'd7) ? PARITY : DATA;
`else
        stateNext = (wrap && bitIdx == 3'd7) ? STOP : DATA;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx = parBit;
        stateNext = wrap ? STOP : PARITY;
      end
`endif
      STOP: begin
        pop = wrap && !empty;
        stateNext = !wrap ? STOP : empty ? IDLE : START;
      end
      default: stateNext = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: directed, table-driven bench for uart_tx_port at BAUD_DIV=4, FIFO_DEPTH=4
module tb_uart_tx_port;
  localparam logic [31:0] DATA = 32'h1001FFF0;
  localparam logic [31:0] STAT = 32'h1001FFF4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * 4;
  logic clk = 0, reset = 0, MemWrite = 0, MemRead = 0, tx, busy;
  logic [31:0] Address = 0, WriteData = 0, ReadData;
  int checks = 0, errors = 0;
  logic rec = 0;
  logic txQ[$], busyQ[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic we;
    logic re;
    logic [31:0] expRd;
  } vecT;
  vecT vecs[6];

  uart_tx_port #(.BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rec) begin
      txQ.push_back(tx);
      busyQ.push_back(busy);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic expBit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  initial begin
    logic bad, busyBad;
    vecs[0] = '{32'h1001FFF8, 32'h000000AA, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{STAT, 32'h00000011, 1'b1, 1'b0, 32'h2};
    vecs[2] = '{STAT, 32'h0, 1'b0, 1'b1, 32'h2};
    vecs[3] = '{DATA, 32'h0, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{32'h1001FFF5, 32'h0, 1'b0, 1'b1, 32'h0};
    Address = STAT;
    #1;
    chk("reset_tx", 32'(tx), 32'h1);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_status", ReadData, 32'h2);
    repeat (3) tick();
    reset = 1;
    bad = 0;
    repeat (100) begin
      tick();
      if (tx !== 1'b1) bad = 1;
    end
    chk("idle_tx_high", 32'(bad), 32'h0);

    bad = 0;
    for (int v = 0; v < 6; v++) begin
      Address = vecs[v].addr;
      WriteData = vecs[v].wdata;
      MemWrite = vecs[v].we;
      MemRead = vecs[v].re;
      #1;
      chk($sformatf("vec%0d_readdata", v), ReadData, vecs[v].expRd);
      tick();
      if (tx !== 1'b1) bad = 1;
    end
    MemWrite = 0;
    MemRead = 0;
    Address = STAT;
    repeat (20) begin
      tick();
      if (tx !== 1'b1) bad = 1;
    end
    chk("ignored_writes_tx", 32'(bad), 32'h0);
    chk("ignored_writes_status", ReadData, 32'h2);

    Address = DATA;
    WriteData = 32'hFFFFFF55;
    MemWrite = 1;
    tick();
    MemWrite = 0;
    Address = STAT;
    #1;
    chk("push_not_empty", ReadData, 32'h0);
    chk("push_tx_still_high", 32'(tx), 32'h1);
    tick();
    chk("start_tx_low", 32'(tx), 32'h0);
    busyBad = 0;
    for (int k = 0; k < NB; k++) begin
      bad = 0;
      for (int c = 0; c < 4; c++) begin
        if (tx !== expBit(8'h55, k)) bad = 1;
        if (busy !== 1'b1) busyBad = 1;
        tick();
      end
      chk($sformatf("frame55_bit%0d", k), 32'(bad), 32'h0);
    end
    chk("frame55_busy_high", 32'(busyBad), 32'h0);
    chk("frame55_end_busy", 32'(busy), 32'h0);
    chk("frame55_end_tx", 32'(tx), 32'h1);

    Address = DATA;
    MemWrite = 1;
    for (int d = 1; d <= 6; d++) begin
      WriteData = 32'(d);
      tick();
      rec = 1;
    end
    MemWrite = 0;
    Address = STAT;
    MemRead = 1;
    #1;
    chk("overflow_status", ReadData, 32'hD);
    tick();
    chk("overflow_cleared", ReadData, 32'h5);
    MemRead = 0;
    for (int n = 0; n < 400 && txQ.size() < 5 * FL + 20; n++) tick();
    rec = 0;
    chk("capture_length", 32'(txQ.size()), 32'(5 * FL + 20));
    if (txQ.size() >= 5 * FL + 20) begin
      busyBad = 0;
      for (int f = 0; f < 5; f++) begin
        bad = 0;
        for (int i = 0; i < FL; i++) begin
          if (txQ[f*FL+i] !== expBit(8'(f + 1), i / 4)) bad = 1;
          if (busyQ[f*FL+i] !== 1'b1) busyBad = 1;
        end
        chk($sformatf("burst_frame%0d", f + 1), 32'(bad), 32'h0);
      end
      chk("burst_busy_no_gap", 32'(busyBad), 32'h0);
      bad = 0;
      for (int i = 5 * FL; i < 5 * FL + 20; i++)
        if (txQ[i] !== 1'b1 || busyQ[i] !== 1'b0) bad = 1;
      chk("burst_sixth_dropped", 32'(bad), 32'h0);
    end

    Address = DATA;
    MemWrite = 1;
    WriteData = 32'hA3;
    tick();
    WriteData = 32'h3C;
    tick();
    MemWrite = 0;
    Address = STAT;
    repeat (12) tick();
    chk("midframe_busy", 32'(busy), 32'h1);
    chk("midframe_data_bit2", 32'(tx), 32'(expBit(8'hA3, 3)));
    #3 reset = 0;
    #1;
    chk("abort_tx_high", 32'(tx), 32'h1);
    chk("abort_busy_low", 32'(busy), 32'h0);
    chk("abort_status", ReadData, 32'h2);
    repeat (2) tick();
    reset = 1;
    bad = 0;
    repeat (100) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1;
    end
    chk("abort_no_residual", 32'(bad), 32'h0);
    chk("abort_final_status", ReadData, 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
